// File: rtl/demux4_pkg.sv
// rtl/demux4_pkg.sv - shared types and sizing helpers for the 4-channel TDM demultiplexer
package demux4_pkg;

  typedef enum logic {HUNT, RUN} state_t;

  localparam int NUM_SLOTS = 4;

  // Bit counter must stay at least one bit wide even when a slot is a single bit.
  function automatic int cnt_width(input int width);
    int c;
    c = $clog2(width);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/slot_sipo.sv
// rtl/slot_sipo.sv - WIDTH-bit serial-in/parallel-out shadow register, MSB first
module slot_sipo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH:0] ext;

  assign ext = {data, din};

  // A clear that coincides with a shift loads the new bit, so a frame-start
  // bit lands as bit 0 of a fresh slot.
  always_ff @(posedge clk) begin
    if (clear) begin
      data <= shift ? WIDTH'(din) : '0;
    end else if (shift) begin
      data <= ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/demux4_tdm.sv
// rtl/demux4_tdm.sv - framed serial link demultiplexer onto four double-buffered channel registers
module demux4_tdm
  import demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [1:0]       slot
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_q, bit_d, eff_bit;
  logic [1:0]      slot_q, slot_d, eff_slot;
  logic            start, accept, mid_sync, last_bit, last_frame;
  logic [WIDTH-1:0] shadow [NUM_SLOTS];

  // A sync bit always counts as frame bit 0, overriding wherever the counters were.
  always_comb begin
    start      = en & sync;
    accept     = en & ((state_q == RUN) | sync);
    mid_sync   = start & (state_q == RUN);
    eff_bit    = sync ? '0 : bit_q;
    eff_slot   = sync ? 2'd0 : slot_q;
    last_bit   = (eff_bit == LAST_BIT);
    last_frame = last_bit & (eff_slot == 2'd3);

    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    if (accept) begin
      if (last_frame) begin
        state_d = HUNT;
        bit_d   = '0;
        slot_d  = 2'd0;
      end else begin
        state_d = RUN;
        if (last_bit) begin
          bit_d  = '0;
          slot_d = eff_slot + 2'd1;
        end else begin
          bit_d  = eff_bit + CW'(1);
          slot_d = eff_slot;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    slot_sipo #(.WIDTH(WIDTH)) u_sipo (
      .clk   (clk),
      .clear (reset | start),
      .shift (accept & (eff_slot == 2'(k))),
      .din   (din),
      .data  (shadow[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      bit_q       <= '0;
      slot_q      <= 2'd0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_d       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      frame_valid <= accept & last_frame;
      sync_err    <= mid_sync;
      // Slot 3's final bit is still on din, so it is merged in as the outputs load.
      if (accept & last_frame) begin
        out_a <= shadow[0];
        out_b <= shadow[1];
        out_c <= shadow[2];
        out_d <= WIDTH'({shadow[NUM_SLOTS-1], din});
      end
    end
  end

  assign slot = slot_q;

endmodule

// File: tb/tb_demux4_tdm.sv
// tb/tb_demux4_tdm.sv - self-checking bench for demux4_tdm at WIDTH=1 and WIDTH=4
module tb_demux4_tdm;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, din1, sync1, en4, din4, sync4;
  logic       a1, b1, c1, d1, fv1, err1;
  logic [1:0] slot1;
  logic [3:0] a4, b4, c4, d4;
  logic       fv4, err4;
  logic [1:0] slot4;

  int checks = 0;
  int failures = 0;

  int m_w   [2];
  bit m_run [2];
  int m_pos [2];
  int m_sh  [2][4];
  int m_out [2][4];
  bit e_fv  [2];
  bit e_err [2];
  int e_slot[2];

  demux4_tdm #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .din(din1), .en(en1), .sync(sync1),
    .out_a(a1), .out_b(b1), .out_c(c1), .out_d(d1),
    .frame_valid(fv1), .sync_err(err1), .slot(slot1)
  );

  demux4_tdm #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .din(din4), .en(en4), .sync(sync4),
    .out_a(a4), .out_b(b4), .out_c(c4), .out_d(d4),
    .frame_valid(fv4), .sync_err(err4), .slot(slot4)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pos[i] = 0; e_fv[i] = 0; e_err[i] = 0; e_slot[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_sh[i][k] = 0; m_out[i][k] = 0;
      end
    end
  endtask

  // Frame viewed as a flat list of 4*W bits indexed by position since the last sync.
  task automatic model_step(input int i, input bit e, input bit d, input bit s);
    int k;
    e_fv[i] = 0; e_err[i] = 0;
    if (!e) return;
    if (s) begin
      if (m_run[i]) e_err[i] = 1;
      m_run[i] = 1; m_pos[i] = 0;
      for (int j = 0; j < 4; j++) m_sh[i][j] = 0;
    end
    if (!m_run[i]) return;
    k = m_pos[i] / m_w[i];
    m_sh[i][k] = ((m_sh[i][k] * 2) + int'(d)) % (1 << m_w[i]);
    m_pos[i]++;
    if (m_pos[i] == 4 * m_w[i]) begin
      for (int j = 0; j < 4; j++) m_out[i][j] = m_sh[i][j];
      e_fv[i] = 1; m_run[i] = 0; m_pos[i] = 0;
    end
    e_slot[i] = m_pos[i] / m_w[i];
  endtask

  function automatic logic [19:0] obs_stat(input int i);
    if (i == 0) return {3'b0, a1, 3'b0, b1, 3'b0, c1, 3'b0, d1, fv1, err1, slot1};
    return {a4, b4, c4, d4, fv4, err4, slot4};
  endfunction

  function automatic logic [19:0] exp_stat(input int i);
    return {4'(m_out[i][0]), 4'(m_out[i][1]), 4'(m_out[i][2]), 4'(m_out[i][3]),
            e_fv[i], e_err[i], 2'(e_slot[i])};
  endfunction

  task automatic drive(input int i, input bit e, input bit d, input bit s, input bit r);
    reset = r;
    if (i == 0) begin
      en1 = e; din1 = d; sync1 = s; en4 = 0; din4 = 1'($urandom); sync4 = 1'($urandom);
    end else begin
      en4 = e; din4 = d; sync4 = s; en1 = 0; din1 = 1'($urandom); sync1 = 1'($urandom);
    end
    @(posedge clk);
    if (r) model_reset();
    else begin
      model_step(i, e, d, s);
      model_step(1 - i, 0, 0, 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(c, 1'($urandom), 1'($urandom), 1'($urandom), 1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_stat(i) !== 20'h0) begin
          failures++;
          $display("FAIL reset inst=%0d got=%h exp=%h", i, obs_stat(i), 20'h0);
        end
      end
    end
  endtask

  task automatic test_w1_frame();
    bit b [4] = '{1, 0, 1, 1};
    for (int j = 0; j < 4; j++) begin
      drive(0, 1, b[j], j == 0, 0);
      checks++;
      if (obs_stat(0) !== exp_stat(0)) begin
        failures++;
        $display("FAIL w1_frame bit=%0d got=%h exp=%h", j, obs_stat(0), exp_stat(0));
      end
    end
    checks++;
    if ({a1, b1, c1, d1, fv1} !== 5'b10111) begin
      failures++;
      $display("FAIL w1_frame_out got=%b exp=%b", {a1, b1, c1, d1, fv1}, 5'b10111);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (fv1 !== 1'b0) begin
      failures++;
      $display("FAIL w1_fv_width got=%b exp=0", fv1);
    end
  endtask

  task automatic test_w4_gaps();
    logic [3:0] nib [4] = '{4'hA, 4'h3, 4'hF, 4'h0};
    for (int s = 0; s < 4; s++) begin
      for (int bi = 3; bi >= 0; bi--) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          drive(1, 0, 1'($urandom), 1'($urandom), 0);
          checks++;
          if (obs_stat(1) !== exp_stat(1)) begin
            failures++;
            $display("FAIL w4_gap got=%h exp=%h", obs_stat(1), exp_stat(1));
          end
        end
        drive(1, 1, nib[s][bi], (s == 0) && (bi == 3), 0);
        checks++;
        if (obs_stat(1) !== exp_stat(1)) begin
          failures++;
          $display("FAIL w4_bit slot=%0d bit=%0d got=%h exp=%h", s, bi, obs_stat(1), exp_stat(1));
        end
      end
      checks++;
      if (slot4 !== 2'((s + 1) % 4)) begin
        failures++;
        $display("FAIL w4_slot_step got=%0d exp=%0d", slot4, (s + 1) % 4);
      end
    end
    checks++;
    if ({a4, b4, c4, d4} !== 16'hA3F0) begin
      failures++;
      $display("FAIL w4_out got=%h exp=%h", {a4, b4, c4, d4}, 16'hA3F0);
    end
  endtask

  task automatic test_mid_sync();
    bit b [6] = '{1, 0, 0, 1, 1, 0};
    bit s [6] = '{1, 0, 1, 0, 0, 0};
    int errs = 0, fvs = 0;
    for (int j = 0; j < 8; j++) begin
      if (j < 6) drive(0, 1, b[j], s[j], 0);
      else drive(0, 0, 0, 0, 0);
      errs += int'(err1); fvs += int'(fv1);
      checks++;
      if (obs_stat(0) !== exp_stat(0)) begin
        failures++;
        $display("FAIL mid_sync step=%0d got=%h exp=%h", j, obs_stat(0), exp_stat(0));
      end
    end
    checks++;
    if (errs != 1 || fvs != 1 || {a1, b1, c1, d1} !== 4'b0110) begin
      failures++;
      $display("FAIL mid_sync_sum errs=%0d fvs=%0d out=%b exp errs=1 fvs=1 out=0110",
               errs, fvs, {a1, b1, c1, d1});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] frame;
    int errs = 0;
    frame = 16'($urandom);
    for (int j = 0; j < 5; j++) drive(1, 1, 1'($urandom), j == 0, 0);
    drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1);
    for (int j = 15; j >= 0; j--) begin
      drive(1, 1, frame[j], j == 15, 0);
      errs += int'(err4);
      checks++;
      if (obs_stat(1) !== exp_stat(1)) begin
        failures++;
        $display("FAIL reset_mid bit=%0d got=%h exp=%h", j, obs_stat(1), exp_stat(1));
      end
      if (j == 1) begin
        checks++;
        if ({a4, b4, c4, d4} !== 16'h0) begin
          failures++;
          $display("FAIL reset_mid_hold got=%h exp=0000", {a4, b4, c4, d4});
        end
      end
    end
    checks++;
    if (errs != 0 || {a4, b4, c4, d4} !== frame) begin
      failures++;
      $display("FAIL reset_mid_out errs=%0d out=%h exp errs=0 out=%h", errs, {a4, b4, c4, d4}, frame);
    end
  endtask

  task automatic test_back_to_back();
    bit b [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int fvs = 0;
    for (int j = 0; j < 13; j++) begin
      if (j < 8) drive(0, 1, b[j], (j % 4) == 0, 0);
      else if (j < 12) drive(0, 1, 1'($urandom), 0, 0);
      else drive(0, 0, 0, 0, 0);
      fvs += int'(fv1);
      checks++;
      if (obs_stat(0) !== exp_stat(0)) begin
        failures++;
        $display("FAIL b2b step=%0d got=%h exp=%h", j, obs_stat(0), exp_stat(0));
      end
    end
    checks++;
    if (fvs != 2 || {a1, b1, c1, d1} !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_sum fvs=%0d out=%b exp fvs=2 out=0001", fvs, {a1, b1, c1, d1});
    end
  endtask

  task automatic test_random();
    bit e, s;
    for (int n = 0; n < 400; n++) begin
      int i;
      i = n % 2;
      e = ($urandom_range(0, 3) != 0);
      s = m_run[i] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      drive(i, e, 1'($urandom), s, 0);
      checks++;
      if (obs_stat(i) !== exp_stat(i)) begin
        failures++;
        $display("FAIL random n=%0d inst=%0d got=%h exp=%h", n, i, obs_stat(i), exp_stat(i));
      end
    end
  endtask

  initial begin
    m_w[0] = 1; m_w[1] = 4;
    reset = 1; en1 = 0; din1 = 0; sync1 = 0; en4 = 0; din4 = 0; sync4 = 0;
    model_reset();
    test_reset();
    test_w1_frame();
    test_w4_gaps();
    test_mid_sync();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
